// File: rtl/core_pkg.sv
// Shared encodings for the core: scheduler state bus, fetcher handshake and
// LSU lane states. Imported by the scheduler, fetcher, LSUs and PC units.
package core_pkg;

   // Fixed encodings; the PC units decode EXECUTE and UPDATE directly.
   typedef enum logic [2:0] {
      CORE_IDLE    = 3'd0,
      CORE_FETCH   = 3'd1,
      CORE_DECODE  = 3'd2,
      CORE_REQUEST = 3'd3,
      CORE_WAIT    = 3'd4,
      CORE_EXECUTE = 3'd5,
      CORE_UPDATE  = 3'd6,
      CORE_DONE    = 3'd7
   } core_state_t;

   localparam logic [2:0] FETCHER_FETCHED = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE       = 2'd0,
      LSU_REQUESTING = 2'd1,
      LSU_WAITING    = 2'd2,
      LSU_DONE       = 2'd3
   } lsu_state_t;

   // A lane holds the core in WAIT while its memory access is outstanding.
   function automatic logic lsu_busy(input logic [1:0] s);
      return (s == LSU_REQUESTING) || (s == LSU_WAITING);
   endfunction

endpackage

// File: rtl/lane_mask.sv
// Thread-count to lane-enable decoder. Lanes 0..count-1 are enabled; counts
// above LANES saturate to all lanes enabled.
module lane_mask #(
   parameter int LANES = 4,
   parameter int CNT_W = $clog2(LANES) + 1
) (
   input  logic [CNT_W-1:0] count,
   output logic [LANES-1:0] mask
);

   // Thermometer decode; the compare saturates naturally for oversize counts.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      mask = '0;
      for (int i = 0; i < LANES; i++) begin
         mask[i] = (count > CNT_W'(i));
      end
   end

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction-cycle sequencer. Walks one thread block through
// FETCH..UPDATE, owns current_pc, flags lane divergence and signals RET.
module core_scheduler #(
   parameter int THREADS_PER_BLOCK     = 4,
   parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               start,
   input  logic [$clog2(THREADS_PER_BLOCK):0]                 thread_count,
   input  logic [2:0]                                         fetcher_state,
   input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
   input  logic                                               decoded_ret,
   input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
   output logic [2:0]                                         core_state,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
   output logic                                               done,
   output logic                                               diverged
);

   import core_pkg::*;

   localparam int T = THREADS_PER_BLOCK;
   localparam int A = PROGRAM_MEM_ADDR_BITS;

   core_state_t    state;
   logic [T-1:0]   lane_en;
   logic [A-1:0]   sel_pc;
   logic           lanes_busy;
   logic           lanes_differ;

   lane_mask #(
      .LANES (T),
      .CNT_W ($clog2(T) + 1)
   ) u_lane_mask (
      .count (thread_count),
      .mask  (lane_en)
   );

   // Enabled lanes are always contiguous from 0, so lane 0 is the lowest
   // enabled lane (and the fallback when none are enabled). Disabled lanes
   // neither stall WAIT nor count toward divergence.
   always_comb begin
      sel_pc       = next_pc[A-1:0];
      lanes_busy   = 1'b0;
      lanes_differ = 1'b0;
      for (int i = 0; i < T; i++) begin
         if (lane_en[i] && lsu_busy(lsu_state[2*i +: 2])) lanes_busy = 1'b1;
         if (lane_en[i] && (next_pc[A*i +: A] != sel_pc))  lanes_differ = 1'b1;
      end
   end

   // Instruction-cycle FSM with registered pc, done and divergence flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= CORE_IDLE;
         current_pc <= '0;
         done       <= 1'b0;
         diverged   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
         case (state)
            CORE_IDLE: begin
               if (start) begin
                  state      <= CORE_FETCH;
                  current_pc <= '0;
                  diverged   <= 1'b0;
               end
            end
            CORE_FETCH: begin
               if (fetcher_state == FETCHER_FETCHED) state <= CORE_DECODE;
            end
            CORE_DECODE:  state <= CORE_REQUEST;
            CORE_REQUEST: state <= CORE_WAIT;
            CORE_WAIT: begin
               if (!lanes_busy) state <= CORE_EXECUTE;
            end
            CORE_EXECUTE: state <= CORE_UPDATE;
            CORE_UPDATE: begin
               if (lanes_differ) diverged <= 1'b1;
               if (decoded_ret) begin
                  state <= CORE_DONE;
                  done  <= 1'b1;
               end else begin
                  current_pc <= sel_pc;
                  state      <= CORE_FETCH;
               end
            end
            CORE_DONE: begin
               if (!start) begin
                  state <= CORE_IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= CORE_IDLE;
         endcase
      end
   end

   assign core_state = state;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: straight-line flow, LSU stalls, lane
// masking, branches/divergence, RET handshake, PC wrap and async reset.
module tb_core_scheduler;

   import core_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  thread_count;
   logic [2:0]  fetcher_state;
   logic [7:0]  lsu_state;
   logic        decoded_ret;
   logic [31:0] next_pc;
   logic [2:0]  core_state;
   logic [7:0]  current_pc;
   logic        done;
   logic        diverged;

   int n_checks = 0;
   int n_fail   = 0;

   core_scheduler #(
      .THREADS_PER_BLOCK     (4),
      .PROGRAM_MEM_ADDR_BITS (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .thread_count  (thread_count),
      .fetcher_state (fetcher_state),
      .lsu_state     (lsu_state),
      .decoded_ret   (decoded_ret),
      .next_pc       (next_pc),
      .core_state    (core_state),
      .current_pc    (current_pc),
      .done          (done),
      .diverged      (diverged)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pcs(input logic [7:0] l0, input logic [7:0] l1,
                          input logic [7:0] l2, input logic [7:0] l3);
      next_pc = {l3, l2, l1, l0};
   endtask

   task automatic set_lsu(input int lane, input logic [1:0] val);
      lsu_state[2*lane +: 2] = val;
   endtask

   // From FETCH with no stalls: walk to UPDATE and take the UPDATE edge.
   task automatic run_instr(input string tag);
      step(); check({tag, " decode"},  core_state, 3'd2);
      step(); check({tag, " request"}, core_state, 3'd3);
      step(); check({tag, " wait"},    core_state, 3'd4);
      step(); check({tag, " execute"}, core_state, 3'd5);
      step(); check({tag, " update"},  core_state, 3'd6);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      reset         = 1'b0;
      start         = 1'b0;
      thread_count  = 3'd4;
      fetcher_state = FETCHER_FETCHED;
      lsu_state     = '0;
      decoded_ret   = 1'b0;
      set_pcs(8'h01, 8'h01, 8'h01, 8'h01);

      // Reset state
      #3;
      check("reset state",    core_state, 3'd0);
      check("reset pc",       current_pc, 8'h00);
      check("reset done",     done,       1'b0);
      check("reset diverged", diverged,   1'b0);
      step();
      step();
      reset = 1'b1;
      step();
      check("idle hold", core_state, 3'd0);

      // Straight line: start, 6-cycle instruction, pc reloads to 1
      start = 1'b1;
      step();
      check("start fetch", core_state, 3'd1);
      check("start pc",    current_pc, 8'h00);
      start = 1'b0;
      lat = 0;
      do begin
         step();
         lat++;
      end while (core_state != 3'd1 && lat < 20);
      check("instr latency", lat, 6);
      check("straight pc",   current_pc, 8'h01);

      // LSU stall on lane 2: five WAIT cycles, EXECUTE after lane reads DONE
      step(); check("stall decode",  core_state, 3'd2);
      step(); check("stall request", core_state, 3'd3);
      set_lsu(2, LSU_WAITING);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall wait", core_state, 3'd4);
      end
      set_lsu(2, LSU_DONE);
      step(); check("stall execute", core_state, 3'd5);
      step(); check("stall update",  core_state, 3'd6);
      step(); check("stall fetch",   core_state, 3'd1);
      lsu_state = '0;

      // Same stall with lane 2 disabled: ignored
      thread_count = 3'd2;
      set_lsu(2, LSU_WAITING);
      step(); check("mask decode",  core_state, 3'd2);
      step(); check("mask request", core_state, 3'd3);
      step(); check("mask wait",    core_state, 3'd4);
      step(); check("mask execute", core_state, 3'd5);
      lsu_state    = '0;
      thread_count = 3'd4;
      step(); check("mask update", core_state, 3'd6);
      step(); check("mask fetch",  core_state, 3'd1);

      // FETCH holds until FETCHED
      fetcher_state = 3'b000;
      step(); check("fetch hold", core_state, 3'd1);
      fetcher_state = FETCHER_FETCHED;

      // Branch, uniform
      set_pcs(8'h1A, 8'h1A, 8'h1A, 8'h1A);
      run_instr("br1");
      check("br1 fetch",    core_state, 3'd1);
      check("br1 pc",       current_pc, 8'h1A);
      check("br1 diverged", diverged,   1'b0);

      // Branch, lane 1 disagrees
      set_pcs(8'h05, 8'h06, 8'h05, 8'h05);
      run_instr("br2");
      check("br2 pc",       current_pc, 8'h05);
      check("br2 diverged", diverged,   1'b1);

      // Divergence is sticky
      set_pcs(8'h07, 8'h07, 8'h07, 8'h07);
      run_instr("br3");
      check("br3 pc",       current_pc, 8'h07);
      check("br3 diverged", diverged,   1'b1);

      // RET retires: DONE, pc unchanged
      decoded_ret = 1'b1;
      set_pcs(8'h20, 8'h20, 8'h20, 8'h20);
      run_instr("ret");
      check("ret state", core_state, 3'd7);
      check("ret done",  done,       1'b1);
      check("ret pc",    current_pc, 8'h07);
      start = 1'b1;
      step();
      check("done ignores start", core_state, 3'd7);
      check("done held",          done,       1'b1);
      start = 1'b0;
      step();
      check("done to idle",   core_state, 3'd0);
      check("done cleared",   done,       1'b0);
      check("idle keeps div", diverged,   1'b1);
      decoded_ret = 1'b0;
      start       = 1'b1;
      step();
      check("restart fetch",   core_state, 3'd1);
      check("restart pc",      current_pc, 8'h00);
      check("restart div clr", diverged,   1'b0);
      start = 1'b0;

      // thread_count=0: no stall, no divergence, lane 0 selected
      thread_count = 3'd0;
      set_lsu(2, LSU_WAITING);
      set_pcs(8'h10, 8'h33, 8'h33, 8'h33);
      run_instr("tc0");
      check("tc0 pc",       current_pc, 8'h10);
      check("tc0 diverged", diverged,   1'b0);
      lsu_state = '0;

      // thread_count=7 clamps to all four lanes enabled
      thread_count = 3'd7;
      step(); check("clamp decode",  core_state, 3'd2);
      step(); check("clamp request", core_state, 3'd3);
      set_lsu(3, LSU_REQUESTING);
      step(); check("clamp wait1",   core_state, 3'd4);
      step(); check("clamp wait2",   core_state, 3'd4);
      lsu_state = '0;
      step(); check("clamp execute", core_state, 3'd5);
      step(); check("clamp update",  core_state, 3'd6);
      step();
      check("clamp pc",       current_pc, 8'h10);
      check("clamp diverged", diverged,   1'b1);
      thread_count = 3'd4;

      // PC wrap
      set_pcs(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      run_instr("wrapa");
      check("wrap pc ff", current_pc, 8'hFF);
      set_pcs(8'h00, 8'h00, 8'h00, 8'h00);
      run_instr("wrapb");
      check("wrap pc 00", current_pc, 8'h00);
      set_pcs(8'h01, 8'h01, 8'h01, 8'h01);
      run_instr("wrapc");
      check("wrap continue state", core_state, 3'd1);
      check("wrap continue pc",    current_pc, 8'h01);

      // Async reset mid-WAIT, between clock edges
      set_lsu(0, LSU_WAITING);
      step(); check("ar decode",  core_state, 3'd2);
      step(); check("ar request", core_state, 3'd3);
      step(); check("ar wait",    core_state, 3'd4);
      #2 reset = 1'b0;
      #1;
      check("async state",    core_state, 3'd0);
      check("async pc",       current_pc, 8'h00);
      check("async done",     done,       1'b0);
      check("async diverged", diverged,   1'b0);
      lsu_state = '0;
      step();
      reset = 1'b1;
      step();
      check("post reset idle", core_state, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
Per-core control FSM that sequences one block of threads through the instruction cycle FETCH→DECODE→REQUEST→WAIT→EXECUTE→UPDATE. It drives the shared core_state bus consumed by the fetcher, decoder, LSUs, ALUs and per-thread PC units. It owns current_pc, reloading it from the per-thread next_pc after each instruction. It raises done when a RET instruction retires.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes in the core
PROGRAM_MEM_ADDR_BITS, 8, width of the PC

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
start  input  1  level; begin executing the block from PC 0
thread_count  input  $clog2(THREADS_PER_BLOCK)+1  active lanes; lanes 0..thread_count-1 are enabled
fetcher_state  input  3  fetcher FSM state; FETCHED=3'b010
lsu_state  input  2*THREADS_PER_BLOCK  per-lane LSU state, lane i at [2i+1:2i]; IDLE=0, REQUESTING=1, WAITING=2, DONE=3
decoded_ret  input  1  current instruction is RET
next_pc  input  PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK  per-lane PC-unit output, lane i at slice i
core_state  output  3  IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7
current_pc  output  PROGRAM_MEM_ADDR_BITS  PC of the instruction in flight
done  output  1  block finished
diverged  output  1  sticky; active lanes disagreed on next_pc

Behaviour:
- Reset (reset=0, asynchronous): core_state=IDLE, current_pc=0, done=0, diverged=0. All other state is registered on clk rising edge only.
- IDLE: if start=1, go to FETCH and load current_pc=0. Otherwise hold.
- FETCH: hold until fetcher_state==FETCHED, then go to DECODE. FETCH lasts at least 1 cycle.
- DECODE: 1 cycle, then REQUEST.
- REQUEST: 1 cycle, then WAIT.
- WAIT: advance to EXECUTE in the first cycle in which no enabled lane has lsu_state equal to REQUESTING or WAITING.
  - Disabled lanes are ignored.
  - Minimum WAIT duration is 1 cycle.
- EXECUTE: 1 cycle, then UPDATE. PC units register next_pc on this edge.
- UPDATE: sample next_pc.
  - If decoded_ret=1: go to DONE, set done=1, leave current_pc unchanged.
  - Otherwise: current_pc <= next_pc of the lowest-index enabled lane (lane 0 if thread_count==0), then go to FETCH.
  - In the same cycle, if any other enabled lane's next_pc differs from the selected one, set diverged=1. diverged stays set until reset or the next IDLE→FETCH.
- DONE: hold done=1. When start=0, go to IDLE and clear done. start=1 in DONE is ignored.
- thread_count > THREADS_PER_BLOCK is clamped to THREADS_PER_BLOCK.
- thread_count==0: WAIT passes in 1 cycle and diverged never sets.
- PC arithmetic wraps modulo 2^PROGRAM_MEM_ADDR_BITS. The scheduler does not modify PC values; it only copies them.
- Minimum instruction latency is 6 cycles (FETCH..UPDATE) when FETCHED is present on the first FETCH cycle and no LSU is busy.
- Reset asserted mid-instruction returns to IDLE immediately, with no completion of the instruction in flight.
- Encodings 0..7 of core_state are fixed; EXECUTE=5 and UPDATE=6 are relied on by the PC units.

Decomposition:
- Shared package core_pkg:
  - core_state encodings
  - fetcher encodings (FETCHED)
  - LSU state encodings
- This module and the fetcher, LSU and PC units all import core_pkg.
- One sub-module is natural: lane_mask, a combinational thread_count → THREADS_PER_BLOCK-bit enable mask with clamping. The same mask drives the per-lane enables in the core.

Test Plan:
- Straight line: thread_count=4, FETCHED on the first FETCH cycle, LSUs IDLE, all next_pc=1 → states 1,2,3,4,5,6,1 and current_pc=1 at the second FETCH; per-instruction latency 6 cycles.
- LSU stall: lane 2 lsu_state=WAITING for 5 cycles during WAIT → WAIT lasts 5 cycles and EXECUTE starts on the cycle after lane 2 reads DONE. Repeat with thread_count=2 → the lane-2 stall is ignored and WAIT lasts 1 cycle.
- Branch: next_pc lanes = {0x1A,0x1A,0x1A,0x1A} at UPDATE → current_pc=0x1A and diverged=0. Then lanes = {0x05,0x06,0x05,0x05} → current_pc=0x05 and diverged=1, which remains set across subsequent instructions.
- RET: decoded_ret=1 at UPDATE with current_pc=0x07 → core_state=DONE, done=1, current_pc stays 0x07. Then start=0 → IDLE with done=0. Then start=1 → current_pc=0 and diverged cleared.
- Async reset: drive reset=0 mid-WAIT between clock edges → core_state=0, current_pc=0, done=0 immediately, without waiting for clk.
- Wrap: current_pc=0xFF and next_pc=0x00 for all lanes → current_pc=0x00 and execution continues normally.
